// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUfun codes, the per-port request bundle and the lock state.
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_A   = 6'b011010;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_GEZ = 6'b111001;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [5:0]       fun;
    logic             sign;
    logic             lock;
  } alu_req_t;

  typedef enum logic [1:0] {
    LK_NONE = 2'b00,
    LK_P0   = 2'b01,
    LK_P1   = 2'b10
  } lock_state_e;

  function automatic logic [1:0] port_onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ALU.sv
// Shared combinational ALU: arithmetic, logic, shifts (amount in A[4:0], data in B) and compares.
module ALU
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [5:0]   ALUFun,
  input  logic         Sign,
  output logic [W-1:0] S
);

  logic [W:0] diff_s;
  logic       lt_s;

  // Extra MSB of the difference is the unsigned borrow; signed compare needs overflow handling
  assign diff_s = {1'b0, A} - {1'b0, B};
  assign lt_s   = Sign ? ((A[W-1] ^ B[W-1]) ? A[W-1] : diff_s[W-1]) : diff_s[W];

  // Function decode; undefined codes produce zero
  always_comb begin
    S = '0;
    case (ALUFun)
      ALU_ADD: S = A + B;
      ALU_SUB: S = diff_s[W-1:0];
      ALU_AND: S = A & B;
      ALU_OR:  S = A | B;
      ALU_XOR: S = A ^ B;
      ALU_NOR: S = ~(A | B);
      ALU_A:   S = A;
      ALU_SLL: S = B << A[4:0];
      ALU_SRL: S = B >> A[4:0];
      ALU_SRA: S = $signed(B) >>> A[4:0];
      ALU_EQ:  S = {{(W-1){1'b0}}, (A == B)};
      ALU_NEQ: S = {{(W-1){1'b0}}, (A != B)};
      ALU_LT:  S = {{(W-1){1'b0}}, lt_s};
      ALU_LEZ: S = {{(W-1){1'b0}}, (A[W-1] | ~(|A))};
      ALU_GEZ: S = {{(W-1){1'b0}}, ~A[W-1]};
      ALU_GTZ: S = {{(W-1){1'b0}}, (~A[W-1] & (|A))};
      default: S = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_grant.sv
// Two-way one-hot grant honouring the lock owner. Round-robin when ALU_ARB_RR_EN is
// defined (last_i = port served last), otherwise port 0 has fixed priority.
module alu_rr_grant
  import alu_pkg::*;
(
  input  logic [1:0]  valid_i,
`ifdef ALU_ARB_RR_EN
  input  logic        last_i,
`endif
  input  lock_state_e lock_i,
  output logic [1:0]  gnt_o
);

  logic [1:0] elig_s;

  // Lock masks out the non-owner even when the owner is idle
  always_comb begin
    elig_s = valid_i;
    case (lock_i)
      LK_P0:   elig_s = valid_i & 2'b01;
      LK_P1:   elig_s = valid_i & 2'b10;
      default: elig_s = valid_i;
    endcase
  end

  // Contention resolution
  always_comb begin
    gnt_o = 2'b00;
    if (elig_s == 2'b11) begin
`ifdef ALU_ARB_RR_EN
      gnt_o = last_i ? 2'b01 : 2'b10;
`else
      gnt_o = 2'b01;
`endif
    end else begin
      gnt_o = elig_s;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared ALU with a one-entry registered response buffer
// and locked sequences. Define ALU_ARB_RR_EN for round-robin, else port 0 has priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NPORT-1:0]       req_valid,
  output logic [NPORT-1:0]       req_ready,
  input  logic [NPORT-1:0][W-1:0] req_a,
  input  logic [NPORT-1:0][W-1:0] req_b,
  input  logic [NPORT-1:0][5:0]  req_fun,
  input  logic [NPORT-1:0]       req_sign,
  input  logic [NPORT-1:0]       req_lock,
  output logic [NPORT-1:0]       rsp_valid,
  input  logic [NPORT-1:0]       rsp_ready,
  output logic [W-1:0]           rsp_s,
  output logic                   busy
);

  logic [1:0]   rsp_valid_q, rsp_valid_d;
  logic [W-1:0] rsp_s_q, rsp_s_d;
  logic         busy_q, busy_d;
  lock_state_e  lock_q, lock_d;
`ifdef ALU_ARB_RR_EN
  logic         last_q, last_d;
`endif

  logic         drain_s, slot_free_s, accept_s, sel_s;
  logic [1:0]   gnt_s;
  logic [W-1:0] alu_s_s;
  alu_req_t     req_s [2];
  alu_req_t     win_s;

  // Bundle each port's request fields
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req_s[i].a    = req_a[i];
      req_s[i].b    = req_b[i];
      req_s[i].fun  = req_fun[i];
      req_s[i].sign = req_sign[i];
      req_s[i].lock = req_lock[i];
    end
  end

  alu_rr_grant u_grant (
    .valid_i (req_valid),
`ifdef ALU_ARB_RR_EN
    .last_i  (last_q),
`endif
    .lock_i  (lock_q),
    .gnt_o   (gnt_s)
  );

  // Grants are suppressed while reset is asserted so nothing is accepted during it
  assign drain_s     = |(rsp_valid_q & rsp_ready);
  assign slot_free_s = (rsp_valid_q == 2'b00) | drain_s;
  assign req_ready   = (reset & slot_free_s) ? gnt_s : 2'b00;
  assign accept_s    = |(req_valid & req_ready);
  assign sel_s       = req_ready[1];
  assign win_s       = sel_s ? req_s[1] : req_s[0];

  ALU #(.W(W)) u_alu (
    .A      (win_s.a),
    .B      (win_s.b),
    .ALUFun (win_s.fun),
    .Sign   (win_s.sign),
    .S      (alu_s_s)
  );

  // Lock FSM next state: every accept re-evaluates ownership from the op's lock bit
  always_comb begin
    lock_d = lock_q;
    if (accept_s) begin
      if (win_s.lock) begin
        lock_d = sel_s ? LK_P1 : LK_P0;
      end else begin
        lock_d = LK_NONE;
      end
    end else begin
      lock_d = lock_q;
    end
  end

  // Response buffer: a same-edge accept replaces a draining result without a gap
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_s_d     = rsp_s_q;
`ifdef ALU_ARB_RR_EN
    last_d      = last_q;
`endif
    if (accept_s) begin
      rsp_valid_d = port_onehot(sel_s);
      rsp_s_d     = alu_s_s;
`ifdef ALU_ARB_RR_EN
      last_d      = sel_s;
`endif
    end else if (drain_s) begin
      rsp_valid_d = 2'b00;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
    busy_d = (|rsp_valid_d) | (lock_d != LK_NONE);
  end

  // State registers; pointer resets to "port 1 served last"
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 2'b00;
      rsp_s_q     <= '0;
      busy_q      <= 1'b0;
      lock_q      <= LK_NONE;
`ifdef ALU_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_s_q     <= rsp_s_d;
      busy_q      <= busy_d;
      lock_q      <= lock_d;
`ifdef ALU_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_s     = rsp_s_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: ALU vector table, hand-written arbitration
// sequences and a randomized run against a behavioural model.
module tb_alu_arbiter;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][5:0]  req_fun;
  logic [1:0]       req_sign;
  logic [1:0]       req_lock;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_s;
  logic             busy;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
    .req_sign(req_sign), .req_lock(req_lock),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: held result owner (-1 none), value, last served, lock owner (-1 none)
  int          m_held;
  logic [31:0] m_s;
  int          m_last;
  int          m_lock;
  int          m_win;
  logic [1:0]  m_ready;
  logic [1:0]  seen_ready;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    logic        sg;
    logic [31:0] exp_s;
  } vec_t;

  vec_t        tbl [17];
  logic [5:0]  codes [16];
  logic [31:0] cs_s [4];
  logic [1:0]  cs_v [4];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f, input logic sg);
    logic [31:0] r;
    r = 32'd0;
    case (f)
      6'b000000: r = a + b;
      6'b000001: r = a - b;
      6'b011000: r = a & b;
      6'b011110: r = a | b;
      6'b010110: r = a ^ b;
      6'b010001: r = ~(a | b);
      6'b011010: r = a;
      6'b100000: r = b << a[4:0];
      6'b100001: r = b >> a[4:0];
      6'b100011: r = $signed(b) >>> a[4:0];
      6'b110011: r = (a == b) ? 32'd1 : 32'd0;
      6'b110001: r = (a != b) ? 32'd1 : 32'd0;
      6'b110101: r = (sg ? ($signed(a) < $signed(b)) : (a < b)) ? 32'd1 : 32'd0;
      6'b111101: r = ($signed(a) <= 0) ? 32'd1 : 32'd0;
      6'b111001: r = ($signed(a) >= 0) ? 32'd1 : 32'd0;
      6'b111111: r = ($signed(a) > 0) ? 32'd1 : 32'd0;
      default:   r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] exp_valid();
    if (m_held < 0) return 2'b00;
    return (m_held == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_reset();
    m_held = -1; m_s = 32'd0; m_last = 1; m_lock = -1; m_win = -1;
  endtask

  task automatic model_comb();
    int  cand[$];
    bit  free;
    free = (m_held < 0) || rsp_ready[m_held];
    cand = {};
    for (int p = 0; p < 2; p++)
      if (req_valid[p] && (m_lock < 0 || m_lock == p)) cand.push_back(p);
    m_win = -1;
    if (free && reset) begin
      if (cand.size() == 1) m_win = cand[0];
      else if (cand.size() == 2) begin
`ifdef ALU_ARB_RR_EN
        m_win = (m_last == 0) ? 1 : 0;
`else
        m_win = 0;
`endif
      end
    end
    m_ready = (m_win < 0) ? 2'b00 : ((m_win == 0) ? 2'b01 : 2'b10);
  endtask

  task automatic model_seq();
    if (m_win >= 0) begin
      m_s    = ref_alu(req_a[m_win], req_b[m_win], req_fun[m_win], req_sign[m_win]);
      m_held = m_win;
      m_last = m_win;
      m_lock = req_lock[m_win] ? m_win : -1;
    end else if (m_held >= 0 && rsp_ready[m_held]) begin
      m_held = -1;
    end
  endtask

  // entered at posedge+1 with inputs applied; leaves at the next posedge+1
  task automatic cycle(input string tag);
    model_comb();
    #3;
    seen_ready = req_ready;
    check({tag, " req_ready"}, {62'd0, req_ready}, {62'd0, m_ready});
    @(posedge clk);
    #1;
    model_seq();
    check({tag, " rsp_valid"}, {62'd0, rsp_valid}, {62'd0, exp_valid()});
    check({tag, " rsp_s"}, {32'd0, rsp_s}, {32'd0, m_s});
    check({tag, " busy"}, {63'd0, busy}, {63'd0, (m_held >= 0 || m_lock >= 0)});
  endtask

  task automatic clear_req();
    req_valid = 2'b00; req_a = '0; req_b = '0; req_fun = '0; req_sign = 2'b00; req_lock = 2'b00;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] f, input logic sg, input logic lk);
    req_valid[p] = 1'b1; req_a[p] = a; req_b[p] = b; req_fun[p] = f;
    req_sign[p] = sg; req_lock[p] = lk;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_req();
    rsp_ready = 2'b00;
    #1;
    model_reset();
    check("reset rsp_valid", {62'd0, rsp_valid}, 64'd0);
    check("reset rsp_s", {32'd0, rsp_s}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset req_ready", {62'd0, req_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{32'd5, 32'd3, 6'b000000, 1'b0, 32'd8};
    tbl[1]  = '{32'd10, 32'd4, 6'b000001, 1'b0, 32'd6};
    tbl[2]  = '{32'hF0F0_1234, 32'h0FF0_FFFF, 6'b011000, 1'b0, 32'h00F0_1234};
    tbl[3]  = '{32'hF000_0000, 32'h0000_000F, 6'b011110, 1'b0, 32'hF000_000F};
    tbl[4]  = '{32'hFFFF_0000, 32'h0F0F_0F0F, 6'b010110, 1'b0, 32'hF0F0_0F0F};
    tbl[5]  = '{32'hF0F0_F0F0, 32'h0F0F_0000, 6'b010001, 1'b0, 32'h0000_0F0F};
    tbl[6]  = '{32'h1234_5678, 32'hDEAD_BEEF, 6'b011010, 1'b0, 32'h1234_5678};
    tbl[7]  = '{32'd4, 32'h0000_00FF, 6'b100000, 1'b0, 32'h0000_0FF0};
    tbl[8]  = '{32'd4, 32'hA000_0000, 6'b100001, 1'b0, 32'h0A00_0000};
    tbl[9]  = '{32'd4, 32'hA000_0000, 6'b100011, 1'b0, 32'hFA00_0000};
    tbl[10] = '{32'd7, 32'd7, 6'b110011, 1'b0, 32'd1};
    tbl[11] = '{32'd7, 32'd7, 6'b110001, 1'b0, 32'd0};
    tbl[12] = '{32'hFFFF_FFFF, 32'd1, 6'b110101, 1'b1, 32'd1};
    tbl[13] = '{32'hFFFF_FFFF, 32'd1, 6'b110101, 1'b0, 32'd0};
    tbl[14] = '{32'd0, 32'd0, 6'b111101, 1'b0, 32'd1};
    tbl[15] = '{32'h8000_0000, 32'd0, 6'b111001, 1'b0, 32'd0};
    tbl[16] = '{32'd5, 32'd0, 6'b111111, 1'b0, 32'd1};
    for (int i = 0; i < 16; i++) codes[i] = tbl[i + 1].fun;
    codes[0] = 6'b000000;
    codes[12] = 6'b111101;
`ifdef ALU_ARB_RR_EN
    cs_s = '{32'd6, 32'd1, 32'd6, 32'd1};
    cs_v = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    cs_s = '{32'd6, 32'd6, 32'd6, 32'd6};
    cs_v = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    do_reset();

    // ALU vectors through port 0
    for (int i = 0; i < 17; i++) begin
      clear_req();
      rsp_ready = 2'b11;
      set_port(0, tbl[i].a, tbl[i].b, tbl[i].fun, tbl[i].sg, 1'b0);
      cycle($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d grant", i), {62'd0, seen_ready}, 64'd1);
      check($sformatf("tbl%0d result", i), {32'd0, rsp_s}, {32'd0, tbl[i].exp_s});
    end

    // contention straight after reset
    do_reset();
    rsp_ready = 2'b11;
    set_port(0, 32'd10, 32'd4, 6'b000001, 1'b0, 1'b0);
    set_port(1, 32'd7, 32'd7, 6'b110011, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle($sformatf("cont%0d", i));
      check($sformatf("cont%0d valid", i), {62'd0, rsp_valid}, {62'd0, cs_v[i]});
      check($sformatf("cont%0d result", i), {32'd0, rsp_s}, {32'd0, cs_s[i]});
    end

    // backpressure, non-addressed rsp_ready ignored, then drain+accept together
    do_reset();
    rsp_ready = 2'b01;
    set_port(0, 32'd5, 32'd3, 6'b000000, 1'b0, 1'b0);
    cycle("bp0");
    set_port(0, 32'd1, 32'd1, 6'b000000, 1'b0, 1'b0);
    rsp_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("bp_hold%0d", i));
      check($sformatf("bp_hold%0d grant", i), {62'd0, seen_ready}, 64'd0);
      check($sformatf("bp_hold%0d result", i), {32'd0, rsp_s}, 64'd8);
      check($sformatf("bp_hold%0d busy", i), {63'd0, busy}, 64'd1);
    end
    rsp_ready = 2'b01;
    cycle("bp_rel");
    check("bp_rel grant", {62'd0, seen_ready}, 64'd1);
    check("bp_rel result", {32'd0, rsp_s}, 64'd2);

    // lock sequence owned by port 1
    do_reset();
    rsp_ready = 2'b11;
    set_port(1, 32'd1, 32'd2, 6'b110101, 1'b1, 1'b1);
    cycle("lk_take");
    check("lk_take grant", {62'd0, seen_ready}, 64'd2);
    clear_req();
    set_port(0, 32'd5, 32'd3, 6'b000000, 1'b0, 1'b0);
    cycle("lk_idle");
    check("lk_idle grant", {62'd0, seen_ready}, 64'd0);
    check("lk_idle busy", {63'd0, busy}, 64'd1);
    set_port(1, 32'd5, 32'd0, 6'b111111, 1'b0, 1'b0);
    cycle("lk_rel");
    check("lk_rel grant", {62'd0, seen_ready}, 64'd2);
    req_valid[1] = 1'b0;
    cycle("lk_after");
    check("lk_after grant", {62'd0, seen_ready}, 64'd1);
    check("lk_after result", {32'd0, rsp_s}, 64'd8);

    // asynchronous reset while a locked port-1 result is held
    do_reset();
    rsp_ready = 2'b00;
    set_port(1, 32'd1, 32'd2, 6'b110101, 1'b1, 1'b1);
    cycle("mr_take");
    check("mr_take valid", {62'd0, rsp_valid}, 64'd2);
    set_port(0, 32'd10, 32'd4, 6'b000001, 1'b0, 1'b0);
    set_port(1, 32'd7, 32'd7, 6'b110011, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("mr rsp_valid", {62'd0, rsp_valid}, 64'd0);
    check("mr rsp_s", {32'd0, rsp_s}, 64'd0);
    check("mr busy", {63'd0, busy}, 64'd0);
    check("mr req_ready", {62'd0, req_ready}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    rsp_ready = 2'b11;
    cycle("mr_after");
    check("mr_after grant", {62'd0, seen_ready}, 64'd1);
    check("mr_after result", {32'd0, rsp_s}, 64'd6);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        req_valid[p] = ($urandom_range(0, 3) != 0);
        req_a[p]     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd8 : 32'($urandom);
        req_b[p]     = ($urandom_range(0, 3) == 0) ? req_a[p] : 32'($urandom);
        req_fun[p]   = codes[$urandom_range(0, 15)];
        req_sign[p]  = 1'($urandom_range(0, 1));
        req_lock[p]  = ($urandom_range(0, 3) == 0);
        rsp_ready[p] = ($urandom_range(0, 2) != 0);
      end
      cycle($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
